dot_tracker: RTL and testbench
==============================

Name: dot_tracker

Overview:
- Owns the authoritative dot/energizer state for the 31x28 tile maze and serves it to the dot renderer through a one-cycle-latency video read port.
- Initialises the map from the maze wall ROM after reset or on a level restart.
- Clears a dot when Pac-Man enters its tile, accumulates score, and flags level completion.
- Sits between the Pac-Man movement controller and maze ROM (upstream) and the dot renderer and score display (downstream).

Parameters:
ROWS, 31, maze tile rows
COLS, 28, maze tile columns
DOT_POINTS, 10, score added per normal dot
ENERGIZER_POINTS, 50, score added per energizer
SCORE_W, 20, score width in bits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
level_start  in  1  one-cycle pulse; re-initialises the map and keeps the score
pac_valid  in  1  one-cycle strobe; pac_row/pac_col hold a new Pac-Man tile
pac_row  in  5  Pac-Man tile row
pac_col  in  5  Pac-Man tile column
rd_row  in  5  renderer tile row
rd_col  in  5  renderer tile column
rd_dot  out  1  dot present at (rd_row, rd_col), registered, 1-cycle latency
rd_energizer  out  1  the dot at the read tile is an energizer (registered)
maze_row  out  5  wall ROM address row (used during INIT)
maze_col  out  5  wall ROM address column
maze_wall  in  1  wall ROM data, valid 1 cycle after the address
dot_eaten  out  1  one-cycle pulse when a normal dot is cleared
energizer_eaten  out  1  one-cycle pulse when an energizer is cleared
dots_left  out  10  remaining dot count
score  out  SCORE_W  accumulated score, saturates at all-ones
level_clear  out  1  level-clear flag; held high until level_start
busy  out  1  high while in INIT

Behaviour:
- Storage: dot_map is ROWS x COLS bits, row-major, addressed as row*COLS+col. The video read port and the eat port are independent. The eat path uses read-modify-write.
- Energizer tiles are the constants (3,1), (3,26), (23,1) and (23,26).
- Reset state: FSM in INIT at address 0. All outputs are 0, score is 0, dots_left is 0, and dot_map contents are don't-care until INIT finishes.
- FSM states:
  - INIT: step maze_row/maze_col through all 868 tiles, one per cycle, row-major. With the one-cycle ROM latency, write dot_map[prev] = !maze_wall and increment dots_left when the bit is 1. Exit to IDLE one cycle after the last address; INIT takes 869 cycles. busy = 1 throughout. pac_valid is ignored.
  - IDLE: on pac_valid with an in-range tile (row < ROWS and col < COLS), latch the tile and go to EAT. Out-of-range tiles are ignored.
  - EAT (1 cycle): if dot_map[tile] = 1:
    - clear the bit;
    - decrement dots_left;
    - add DOT_POINTS or ENERGIZER_POINTS, saturating;
    - pulse dot_eaten or energizer_eaten in the following cycle.
    - Then go to CLEAR if dots_left becomes 0, otherwise return to IDLE. If the bit is 0, return to IDLE with no side effects.
  - CLEAR: level_clear = 1. Ignore pac_valid. Stay here until level_start.
- A pac_valid that arrives during EAT is dropped. The movement controller issues at most one strobe per tile change, spaced at least 2 cycles apart.
- level_start from any state:
  - go to INIT at address 0;
  - clear dots_left and level_clear;
  - keep score;
  - an in-progress EAT is abandoned with no score update.
- A level_start pulse during INIT restarts the sweep.
- Reset asserted mid-operation returns immediately to the reset state.
- Video read: rd_dot = dot_map[rd] registered. rd_energizer = rd_dot AND the tile is an energizer. Out-of-range read addresses return 0. During INIT, rd_dot = 0.
- Same-tile collision (rd tile equals the tile cleared in EAT in the same cycle): rd_dot returns the old value. The new value is visible from the next read.
- dots_left is 10 bits wide; 868 fits. Decrement never goes below 0.

Decomposition:
- Package pacman_pkg:
  - MAZE_ROWS and MAZE_COLS;
  - tile_t (a struct of 5-bit row and col);
  - the energizer coordinate constants;
  - DOT_POINTS and ENERGIZER_POINTS;
  - the FSM state enum dot_state_e {INIT, IDLE, EAT, CLEAR}.
- Sub-module dot_ram: 868x1 simple dual-port memory.
  - One registered read port for video.
  - One read/write port for INIT and EAT.
  - Written to infer distributed RAM.

Test Plan:
- Reset, with the wall ROM model returning wall for rows 0 and 30 and open elsewhere. Required: busy for exactly 869 cycles, then dots_left = 812, score = 0, rd_dot = 1 at (1,1), rd_dot = 0 at (0,5).
- pac_valid at (5,5). Required: dot_eaten pulses once, score = 10, dots_left decrements by 1, rd_dot at (5,5) = 0. A repeat pac_valid at (5,5) gives no pulse and no change.
- pac_valid at (3,1). Required: energizer_eaten pulses, score increases by 50. Reading (3,26) before eating it gives rd_energizer = 1.
- ROM model with only 2 open tiles; eat both. Required: level_clear = 1 with dots_left = 0. A later pac_valid is ignored. level_start gives busy, then dots_left = 2, level_clear = 0, score kept at 20.
- Score preset near saturation via repeated eats with SCORE_W = 6. Required: score saturates at 63 and does not wrap.
- level_start asserted during EAT, and separately reset asserted mid-INIT. Required: no score change, the sweep restarts at address 0, all outputs return to their reset values.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared maze geometry, scoring constants and dot-tracker FSM encoding.
package pacman_pkg;

  localparam int unsigned MAZE_ROWS        = 31;
  localparam int unsigned MAZE_COLS        = 28;
  localparam int unsigned MAZE_TILES       = MAZE_ROWS * MAZE_COLS;
  localparam int unsigned DOT_POINTS       = 10;
  localparam int unsigned ENERGIZER_POINTS = 50;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
  } tile_t;

  localparam tile_t ENERGIZER_0 = '{row: 5'd3,  col: 5'd1};
  localparam tile_t ENERGIZER_1 = '{row: 5'd3,  col: 5'd26};
  localparam tile_t ENERGIZER_2 = '{row: 5'd23, col: 5'd1};
  localparam tile_t ENERGIZER_3 = '{row: 5'd23, col: 5'd26};

  typedef enum logic [1:0] {INIT, IDLE, EAT, CLEAR} dot_state_e;

  function automatic logic is_energizer(input tile_t t);
    return (t == ENERGIZER_0) || (t == ENERGIZER_1) ||
           (t == ENERGIZER_2) || (t == ENERGIZER_3);
  endfunction

endpackage

// File: rtl/dot_tracker_ram.sv
// 1-bit-wide dot map: registered video read port plus async-read/sync-write port.
module dot_ram #(
  parameter int unsigned DEPTH = 868,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data,
  input  logic [AW-1:0] rw_addr,
  input  logic          rw_we,
  input  logic          rw_wdata,
  output logic          rw_rdata
);

  logic mem [DEPTH];

  // Video read happens before a same-edge write lands, so it sees the old bit.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (rw_we) mem[rw_addr] <= rw_wdata;
  end

  assign rw_rdata = mem[rw_addr];

endmodule

// File: rtl/dot_tracker.sv
// Authoritative dot/energizer map: initialised from the wall ROM, cleared as
// Pac-Man eats, with score, remaining-dot count and level-clear tracking.
module dot_tracker
  import pacman_pkg::*;
#(
  parameter int unsigned ROWS             = MAZE_ROWS,
  parameter int unsigned COLS             = MAZE_COLS,
  parameter int unsigned DOT_POINTS       = pacman_pkg::DOT_POINTS,
  parameter int unsigned ENERGIZER_POINTS = pacman_pkg::ENERGIZER_POINTS,
  parameter int unsigned SCORE_W          = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               level_start,
  input  logic               pac_valid,
  input  logic [4:0]         pac_row,
  input  logic [4:0]         pac_col,
  input  logic [4:0]         rd_row,
  input  logic [4:0]         rd_col,
  output logic               rd_dot,
  output logic               rd_energizer,
  output logic [4:0]         maze_row,
  output logic [4:0]         maze_col,
  input  logic               maze_wall,
  output logic               dot_eaten,
  output logic               energizer_eaten,
  output logic [9:0]         dots_left,
  output logic [SCORE_W-1:0] score,
  output logic               level_clear,
  output logic               busy
);

  localparam int unsigned TILES = ROWS * COLS;

  dot_state_e state, state_next;

  logic [9:0] cur_addr, prev_addr, eat_addr;
  logic       sweep_done, wr_pend, eat_en;
  logic       commit;
  logic [9:0] ram_addr, vid_addr;
  logic       ram_we, ram_wdata, ram_rdata, vid_data;
  logic       vid_ok, vid_en;
  logic       pac_ok, vid_in_range;
  logic [SCORE_W:0] score_sum;

  assign pac_ok       = (int'(pac_row) < ROWS) && (int'(pac_col) < COLS);
  assign vid_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  assign vid_addr     = vid_in_range ? 10'(int'(rd_row) * COLS + int'(rd_col)) : '0;
  assign ram_addr     = (state == INIT) ? prev_addr : eat_addr;

  assign score_sum = {1'b0, score} + (eat_en ? (SCORE_W+1)'(ENERGIZER_POINTS)
                                             : (SCORE_W+1)'(DOT_POINTS));

  dot_ram #(.DEPTH(TILES), .AW(10)) u_ram (
    .clk      (clk),
    .rd_addr  (vid_addr),
    .rd_data  (vid_data),
    .rw_addr  (ram_addr),
    .rw_we    (ram_we),
    .rw_wdata (ram_wdata),
    .rw_rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wdata  = 1'b0;
    commit     = 1'b0;
    unique case (state)
      INIT: begin
        // ROM data arrives one cycle late, so each write targets the previous address.
        ram_we    = wr_pend;
        ram_wdata = !maze_wall;
        if (sweep_done && wr_pend) state_next = IDLE;
      end
      IDLE: if (pac_valid && pac_ok) state_next = EAT;
      EAT: begin
        if (ram_rdata) begin
          ram_we     = 1'b1;
          commit     = 1'b1;
          state_next = (dots_left == 10'd1) ? CLEAR : IDLE;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: state_next = CLEAR;
      default: state_next = INIT;
    endcase
    if (level_start) begin
      state_next = INIT;
      ram_we     = 1'b0;
      commit     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr        <= '0;
      prev_addr       <= '0;
      eat_addr        <= '0;
      maze_row        <= '0;
      maze_col        <= '0;
      sweep_done      <= 1'b0;
      wr_pend         <= 1'b0;
      eat_en          <= 1'b0;
      dots_left       <= '0;
      score           <= '0;
      dot_eaten       <= 1'b0;
      energizer_eaten <= 1'b0;
    end else if (level_start) begin
      cur_addr        <= '0;
      maze_row        <= '0;
      maze_col        <= '0;
      sweep_done      <= 1'b0;
      wr_pend         <= 1'b0;
      dots_left       <= '0;
      dot_eaten       <= 1'b0;
      energizer_eaten <= 1'b0;
    end else begin
      dot_eaten       <= commit && !eat_en;
      energizer_eaten <= commit && eat_en;
      unique case (state)
        INIT: begin
          if (wr_pend && !maze_wall) dots_left <= dots_left + 10'd1;
          if (!sweep_done) begin
            wr_pend   <= 1'b1;
            prev_addr <= cur_addr;
            if (int'(cur_addr) == TILES - 1) begin
              sweep_done <= 1'b1;
            end else begin
              cur_addr <= cur_addr + 10'd1;
              if (int'(maze_col) == COLS - 1) begin
                maze_col <= '0;
                maze_row <= maze_row + 5'd1;
              end else begin
                maze_col <= maze_col + 5'd1;
              end
            end
          end else begin
            wr_pend <= 1'b0;
          end
        end
        IDLE: begin
          if (pac_valid && pac_ok) begin
            eat_addr <= 10'(int'(pac_row) * COLS + int'(pac_col));
            eat_en   <= is_energizer('{row: pac_row, col: pac_col});
          end
        end
        EAT: begin
          if (commit) begin
            if (dots_left != '0) dots_left <= dots_left - 10'd1;
            score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_ok <= 1'b0;
      vid_en <= 1'b0;
    end else begin
      vid_ok <= vid_in_range && (state != INIT) && !level_start;
      vid_en <= is_energizer('{row: rd_row, col: rd_col});
    end
  end

  assign rd_dot       = vid_data && vid_ok;
  assign rd_energizer = rd_dot && vid_en;
  assign level_clear  = (state == CLEAR);
  assign busy         = (state == INIT);

endmodule

// File: tb/tb_dot_tracker.sv
// Directed bench for dot_tracker: a 20-bit-score instance and a 6-bit-score
// instance share stimulus; each has its own registered wall ROM model.
module tb_dot_tracker;

  logic       clk = 1'b0;
  logic       reset, level_start, pac_valid;
  logic [4:0] pac_row, pac_col, rd_row, rd_col;
  int         rom_mode;

  logic       rd_dot, rd_energizer, dot_eaten, energizer_eaten, level_clear, busy, maze_wall;
  logic [4:0] maze_row, maze_col;
  logic [9:0] dots_left;
  logic [19:0] score;

  logic       rd_dot_s, rd_en_s, dot_eaten_s, en_eaten_s, level_clear_s, busy_s, maze_wall_s;
  logic [4:0] maze_row_s, maze_col_s;
  logic [9:0] dots_left_s;
  logic [5:0] score_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_tracker dut (
    .clk(clk), .reset(reset), .level_start(level_start), .pac_valid(pac_valid),
    .pac_row(pac_row), .pac_col(pac_col), .rd_row(rd_row), .rd_col(rd_col),
    .rd_dot(rd_dot), .rd_energizer(rd_energizer), .maze_row(maze_row),
    .maze_col(maze_col), .maze_wall(maze_wall), .dot_eaten(dot_eaten),
    .energizer_eaten(energizer_eaten), .dots_left(dots_left), .score(score),
    .level_clear(level_clear), .busy(busy)
  );

  dot_tracker #(.SCORE_W(6)) dut_s (
    .clk(clk), .reset(reset), .level_start(level_start), .pac_valid(pac_valid),
    .pac_row(pac_row), .pac_col(pac_col), .rd_row(rd_row), .rd_col(rd_col),
    .rd_dot(rd_dot_s), .rd_energizer(rd_en_s), .maze_row(maze_row_s),
    .maze_col(maze_col_s), .maze_wall(maze_wall_s), .dot_eaten(dot_eaten_s),
    .energizer_eaten(en_eaten_s), .dots_left(dots_left_s), .score(score_s),
    .level_clear(level_clear_s), .busy(busy_s)
  );

  function automatic logic wall_of(input int mode, input logic [4:0] r, input logic [4:0] c);
    if (mode == 0) return (r == 5'd0) || (r == 5'd30);
    return !((r == 5'd1 && c == 5'd1) || (r == 5'd2 && c == 5'd2));
  endfunction

  always @(posedge clk) begin
    maze_wall   <= wall_of(rom_mode, maze_row, maze_col);
    maze_wall_s <= wall_of(rom_mode, maze_row_s, maze_col_s);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] r, input logic [4:0] c,
                    input logic exp_dot, input logic exp_en);
    rd_row = r; rd_col = c;
    @(posedge clk); #1;
    chk({tag, "_dot"}, 32'(rd_dot), 32'(exp_dot));
    chk({tag, "_en"},  32'(rd_energizer), 32'(exp_en));
  endtask

  task automatic eat(input string tag, input logic [4:0] r, input logic [4:0] c,
                     input logic exp_dot, input logic exp_en,
                     input int exp_score, input int exp_score_s, input int exp_left);
    pac_row = r; pac_col = c; pac_valid = 1'b1;
    @(posedge clk); #1;
    pac_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_dot_pulse"}, 32'(dot_eaten), 32'(exp_dot));
    chk({tag, "_en_pulse"},  32'(energizer_eaten), 32'(exp_en));
    chk({tag, "_score"},     32'(score), 32'(exp_score));
    chk({tag, "_score6"},    32'(score_s), 32'(exp_score_s));
    chk({tag, "_left"},      32'(dots_left), 32'(exp_left));
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, 32'(dot_eaten | energizer_eaten), 32'd0);
  endtask

  task automatic pulse_start();
    level_start = 1'b1;
    @(posedge clk); #1;
    level_start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; level_start = 1'b0; pac_valid = 1'b0;
    pac_row = '0; pac_col = '0; rd_row = '0; rd_col = '0; rom_mode = 0;

    repeat (3) @(posedge clk); #1;
    chk("rst_score", 32'(score), 0);
    chk("rst_left", 32'(dots_left), 0);
    chk("rst_rd_dot", 32'(rd_dot), 0);
    chk("rst_clear", 32'(level_clear), 0);
    chk("rst_maze_addr", {maze_row, maze_col}, 0);

    @(negedge clk) reset = 1'b1;
    wait_init(n);
    chk("init_cycles", n, 869);
    chk("init_left", 32'(dots_left), 812);
    chk("init_score", 32'(score), 0);
    rd("rd_1_1", 5'd1, 5'd1, 1'b1, 1'b0);
    rd("rd_0_5", 5'd0, 5'd5, 1'b0, 1'b0);
    rd("rd_oor", 5'd31, 5'd5, 1'b0, 1'b0);

    eat("eat_5_5", 5'd5, 5'd5, 1'b1, 1'b0, 10, 10, 811);
    rd("rd_5_5", 5'd5, 5'd5, 1'b0, 1'b0);
    eat("reeat_5_5", 5'd5, 5'd5, 1'b0, 1'b0, 10, 10, 811);
    rd("rd_3_26", 5'd3, 5'd26, 1'b1, 1'b1);
    eat("eat_3_1", 5'd3, 5'd1, 1'b0, 1'b1, 60, 60, 810);
    eat("eat_10_10", 5'd10, 5'd10, 1'b1, 1'b0, 70, 63, 809);
    eat("eat_10_11", 5'd10, 5'd11, 1'b1, 1'b0, 80, 63, 808);
    eat("eat_oor", 5'd31, 5'd0, 1'b0, 1'b0, 80, 63, 808);

    // Two-open-tile maze; reset asserted while idle.
    rom_mode = 1;
    reset = 1'b0;
    #1;
    chk("rst2_score", 32'(score), 0);
    chk("rst2_left", 32'(dots_left), 0);
    @(negedge clk) reset = 1'b1;
    wait_init(n);
    chk("init2_cycles", n, 869);
    chk("init2_left", 32'(dots_left), 2);
    eat("eat_1_1", 5'd1, 5'd1, 1'b1, 1'b0, 10, 10, 1);
    chk("not_clear", 32'(level_clear), 0);
    eat("eat_2_2", 5'd2, 5'd2, 1'b1, 1'b0, 20, 20, 0);
    chk("clear_set", 32'(level_clear), 1);
    eat("eat_in_clear", 5'd1, 5'd1, 1'b0, 1'b0, 20, 20, 0);
    chk("clear_held", 32'(level_clear), 1);

    pulse_start();
    chk("ls_busy", 32'(busy), 1);
    chk("ls_clear", 32'(level_clear), 0);
    wait_init(n);
    chk("ls_cycles", n, 869);
    chk("ls_left", 32'(dots_left), 2);
    chk("ls_score", 32'(score), 20);

    // level_start during the EAT cycle abandons the eat.
    pac_row = 5'd1; pac_col = 5'd1; pac_valid = 1'b1;
    @(posedge clk); #1;
    pac_valid = 1'b0;
    pulse_start();
    chk("abort_pulse", 32'(dot_eaten), 0);
    chk("abort_score", 32'(score), 20);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_addr", {maze_row, maze_col}, 0);
    wait_init(n);
    chk("abort_left", 32'(dots_left), 2);
    rd("abort_rd_1_1", 5'd1, 5'd1, 1'b1, 1'b0);

    // Restart mid-INIT, then reset mid-INIT.
    pulse_start();
    repeat (100) @(posedge clk); #1;
    chk("mid_init_addr", {maze_row, maze_col}, {5'd3, 5'd16});
    pulse_start();
    chk("restart_addr", {maze_row, maze_col}, 0);
    repeat (50) @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst3_addr", {maze_row, maze_col}, 0);
    chk("rst3_left", 32'(dots_left), 0);
    chk("rst3_score", 32'(score), 0);
    chk("rst3_flags", {rd_dot, level_clear, dot_eaten, energizer_eaten}, 0);
    @(negedge clk) reset = 1'b1;
    wait_init(n);
    chk("init3_cycles", n, 869);
    chk("init3_left", 32'(dots_left), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
